// File: rtl/snake_pkg.sv
// Shared types and screen constants for the snake body controller.
// Holds dir_t, FSM state type, geometry localparams and is_reverse().
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int START_X = 80;
  localparam int START_Y = 60;
  localparam int MAX_LEN = 11;
  localparam int IDX_W   = $clog2(MAX_LEN);

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_step_calc.sv
// Combinational head stepper: head + dir -> next head, out-of-bounds flag.
// Ports: head_x_i/head_y_i, dir_i in; nh_x_o/nh_y_o, oob_o out.
module snake_step_calc
  import snake_pkg::*;
(
  input  logic [7:0] head_x_i,
  input  logic [6:0] head_y_i,
  input  dir_t       dir_i,
  output logic [7:0] nh_x_o,
  output logic [6:0] nh_y_o,
  output logic       oob_o
);

  // Edges are tested before stepping, so there is never a wrap.
  always_comb begin
    nh_x_o = head_x_i;
    nh_y_o = head_y_i;
    oob_o  = 1'b0;
    unique case (1'b1)
      (dir_i == UP): begin
        if (head_y_i == 7'd0) oob_o = 1'b1;
        else nh_y_o = head_y_i - 7'd1;
      end
      (dir_i == DOWN): begin
        if (head_y_i >= 7'(SCR_H - 1)) oob_o = 1'b1;
        else nh_y_o = head_y_i + 7'd1;
      end
      (dir_i == RIGHT): begin
        if (head_x_i >= 8'(SCR_W - 1)) oob_o = 1'b1;
        else nh_x_o = head_x_i + 8'd1;
      end
      default: begin
        if (head_x_i == 8'd0) oob_o = 1'b1;
        else nh_x_o = head_x_i - 8'd1;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body registers: shift, head step, wall/self collision, apple growth.
// Ports: iClock/iReset/iPlay/iMove/iDir/apple_pos_*; body pos, size, pulses, flags.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int INIT_LEN = 3
)
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iPlay,
  input  logic        iMove,
  input  logic [1:0]  iDir,
  input  logic [7:0]  apple_pos_X,
  input  logic [6:0]  apple_pos_Y,
  output logic [7:0]  snake_body_pos_X [MAX_LEN],
  output logic [6:0]  snake_body_pos_Y [MAX_LEN],
  output logic [11:0] size,
  output logic        move_done,
  output logic        ate_apple,
  output logic        game_over,
  output logic        busy
);

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d, dir_new;
  logic [7:0]        pos_x_q [MAX_LEN];
  logic [7:0]        pos_x_d [MAX_LEN];
  logic [6:0]        pos_y_q [MAX_LEN];
  logic [6:0]        pos_y_d [MAX_LEN];
  logic [11:0]       size_q, size_d;
  logic [IDX_W-1:0]  idx_q, idx_d, last_idx;
  logic              eat_q, eat_d;
  logic              go_q, go_d;
  logic [7:0]        nh_x;
  logic [6:0]        nh_y;
  logic              oob;
  logic              hit;

  assign dir_new = is_reverse(dir_t'(iDir), dir_q)
                 ? dir_q : dir_t'(iDir);

  snake_step_calc u_step (
    .head_x_i (pos_x_q[0]),
    .head_y_i (pos_y_q[0]),
    .dir_i    (dir_new),
    .nh_x_o   (nh_x),
    .nh_y_o   (nh_y),
    .oob_o    (oob)
  );

  // Last compared index is size-1; pos[size] is the vacated tail.
  assign last_idx = IDX_W'(size_q - 12'd1);
  assign hit = (pos_x_q[idx_q] == pos_x_q[0]) &&
               (pos_y_q[idx_q] == pos_y_q[0]);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    size_d  = size_q;
    idx_d   = idx_q;
    eat_d   = eat_q;
    go_d    = go_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      pos_x_d[i] = pos_x_q[i];
      pos_y_d[i] = pos_y_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (iMove && iPlay && !go_q) begin
          dir_d = dir_new;
          if (oob) begin
            go_d    = 1'b1;
            eat_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              pos_x_d[i] = pos_x_q[i-1];
              pos_y_d[i] = pos_y_q[i-1];
            end
            pos_x_d[0] = nh_x;
            pos_y_d[0] = nh_y;
            eat_d   = (nh_x == apple_pos_X) &&
                      (nh_y == apple_pos_Y);
            idx_d   = IDX_W'(1);
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (hit) go_d = 1'b1;
        if (idx_q == last_idx) state_d = S_DONE;
        else idx_d = idx_q + IDX_W'(1);
      end
      S_DONE: begin
        if (eat_q && !go_q &&
            size_q < 12'(MAX_LEN - 1))
          size_d = size_q + 12'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      dir_q   <= RIGHT;
      size_q  <= 12'(INIT_LEN);
      idx_q   <= '0;
      eat_q   <= 1'b0;
      go_q    <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        pos_x_q[i] <= 8'(START_X - i);
        pos_y_q[i] <= 7'(START_Y);
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      eat_q   <= eat_d;
      go_q    <= go_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        pos_x_q[i] <= pos_x_d[i];
        pos_y_q[i] <= pos_y_d[i];
      end
    end
  end

  assign snake_body_pos_X = pos_x_q;
  assign snake_body_pos_Y = pos_y_q;
  assign size      = size_q;
  assign game_over = go_q;
  assign move_done = (state_q == S_DONE);
  assign ate_apple = move_done & eat_q & ~go_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: queue-style body model,
// per-cycle compare, directed scenarios plus randomized moves.
module tb_snake_body_ctrl
  import snake_pkg::*;
;

  logic        iClock = 1'b0;
  logic        iReset, iPlay, iMove;
  logic [1:0]  iDir;
  logic [7:0]  apple_x;
  logic [6:0]  apple_y;
  logic [7:0]  px [MAX_LEN];
  logic [6:0]  py [MAX_LEN];
  logic [11:0] size;
  logic        move_done, ate_apple, game_over, busy;

  snake_body_ctrl dut (
    .iClock           (iClock),
    .iReset           (iReset),
    .iPlay            (iPlay),
    .iMove            (iMove),
    .iDir             (iDir),
    .apple_pos_X      (apple_x),
    .apple_pos_Y      (apple_y),
    .snake_body_pos_X (px),
    .snake_body_pos_Y (py),
    .size             (size),
    .move_done        (move_done),
    .ate_apple        (ate_apple),
    .game_over        (game_over),
    .busy             (busy)
  );

  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: body as an array shifted like a queue,
  // collision found by searching the live body, timing by counts.
  int mx [MAX_LEN];
  int my [MAX_LEN];
  int msize, mdir, mphase, mt, mlast, mcoll;
  bit mgo, meat;
  int nd, nx, ny, rd;

  always @(posedge iClock) begin
    if (!iReset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mx[i] = 80 - i;
        my[i] = 60;
      end
      msize = 3; mdir = 1; mgo = 0; mphase = 0; meat = 0;
    end else begin
      case (mphase)
        0: if (iMove && iPlay && !mgo) begin
          rd = int'(iDir);
          nd = ((rd + 2) % 4 == mdir) ? mdir : rd;
          mdir = nd;
          nx = mx[0] + int'(nd == 1) - int'(nd == 3);
          ny = my[0] + int'(nd == 2) - int'(nd == 0);
          if (nx < 0 || nx >= 160 || ny < 0 || ny >= 120) begin
            mgo = 1; meat = 0; mphase = 2;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              mx[i] = mx[i-1];
              my[i] = my[i-1];
            end
            mx[0] = nx; my[0] = ny;
            meat = (nx == int'(apple_x)) && (ny == int'(apple_y));
            mcoll = 0;
            for (int j = msize - 1; j >= 1; j--)
              if (mx[j] == nx && my[j] == ny) mcoll = j;
            mlast = msize - 1; mt = 0; mphase = 1;
          end
        end
        1: begin
          mt++;
          if (mt == mcoll) mgo = 1;
          if (mt == mlast) mphase = 2;
        end
        default: begin
          if (meat && !mgo && msize < 10) msize++;
          mphase = 0;
        end
      endcase
    end
  end

  always @(negedge iClock) begin
    if (cmp_en) begin
      chk("size", int'(size), msize);
      chk("game_over", int'(game_over), int'(mgo));
      chk("move_done", int'(move_done), int'(mphase == 2));
      chk("ate_apple", int'(ate_apple),
          int'(mphase == 2 && meat && !mgo));
      chk("busy", int'(busy), int'(mphase != 0));
      for (int i = 0; i < MAX_LEN; i++) begin
        chk("pos_x", int'(px[i]), mx[i]);
        chk("pos_y", int'(py[i]), my[i]);
      end
    end
  end

  int hx_k, hy_k, p3x_k, p3y_k, go_k, lat, ate_d;

  task automatic do_move(input int d, input int ax, input int ay,
                         input bit extra);
    @(negedge iClock);
    iMove = 1; iDir = 2'(d);
    apple_x = 8'(ax); apple_y = 7'(ay);
    @(negedge iClock);
    iMove = 0;
    hx_k = int'(px[0]); hy_k = int'(py[0]);
    p3x_k = int'(px[3]); p3y_k = int'(py[3]);
    go_k = int'(game_over);
    lat = -1; ate_d = 0;
    for (int i = 0; i < 40; i++) begin
      if (move_done) begin
        lat = i; ate_d = int'(ate_apple);
        break;
      end
      iMove = extra && (i == 0);
      @(negedge iClock);
    end
    iMove = 0;
    chk("move_done_seen", int'(lat >= 0), 1);
  endtask

  task automatic do_reset();
    @(negedge iClock);
    iReset = 0;
    @(negedge iClock);
    iReset = 1;
  endtask

  task automatic idle_pulses(output int seen);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge iClock);
      if (move_done) seen++;
      iMove = (i % 4 == 0);
    end
    iMove = 0;
  endtask

  int n;

  initial begin
    iReset = 0; iPlay = 1; iMove = 0; iDir = 2'd1;
    apple_x = 8'd200; apple_y = 7'd0;
    repeat (3) @(negedge iClock);
    iReset = 1; cmp_en = 1;
    chk("rst_p0x", int'(px[0]), 80); chk("rst_p0y", int'(py[0]), 60);
    chk("rst_p1x", int'(px[1]), 79); chk("rst_p2x", int'(px[2]), 78);
    chk("rst_size", int'(size), 3); chk("rst_go", int'(game_over), 0);

    do_move(1, 81, 60, 0);
    chk("eat_hx", hx_k, 81); chk("eat_hy", hy_k, 60);
    chk("eat_p3x", p3x_k, 78); chk("eat_p3y", p3y_k, 60);
    chk("eat_lat", lat, 2); chk("eat_ate", ate_d, 1);
    @(negedge iClock);
    chk("eat_size", int'(size), 4);

    do_move(3, 200, 0, 1);
    chk("rev_hx", hx_k, 82); chk("rev_lat", lat, 3);
    n = 0;
    repeat (8) begin
      @(negedge iClock);
      if (move_done) n++;
    end
    chk("no_queue", n, 0);

    do_move(0, 200, 0, 0); do_move(1, 200, 0, 0);
    do_move(2, 200, 0, 0); do_move(3, 200, 0, 0);
    chk("tail_hx", hx_k, 82); chk("tail_hy", hy_k, 60);
    chk("tail_go", int'(game_over), 0);

    do_move(3, 81, 60, 0);
    chk("grow5_ate", ate_d, 1);
    repeat (4) do_move(3, 200, 0, 0);
    chk("grow5_size", int'(size), 5);
    chk("grow5_hx", int'(px[0]), 77);

    do_move(0, 200, 0, 0); do_move(3, 200, 0, 0);
    do_move(2, 200, 0, 0); do_move(1, 200, 0, 0);
    chk("self_go_k", go_k, 0); chk("self_go", int'(game_over), 1);
    chk("self_lat", lat, 4); chk("self_ate", ate_d, 0);
    idle_pulses(n);
    chk("dead_no_done", n, 0);

    do_reset();
    do_move(0, 200, 0, 0);
    for (int i = 0; i < 80; i++) do_move(3, 200, 0, 0);
    chk("wall_pre_hx", int'(px[0]), 0);
    do_move(3, 200, 0, 0);
    chk("wall_lat", lat, 0); chk("wall_go", int'(game_over), 1);
    chk("wall_hx", int'(px[0]), 0); chk("wall_hy", int'(py[0]), 59);
    chk("wall_p1x", int'(px[1]), 1);
    idle_pulses(n);
    chk("wall_no_done", n, 0);

    do_reset();
    for (int k = 0; k < 8; k++) begin
      do_move(1, 81 + k, 60, 0);
      chk("sat_ate", ate_d, 1);
    end
    @(negedge iClock);
    chk("sat_size", int'(size), 10);

    @(negedge iClock);
    iMove = 1; iDir = 2'd2;
    @(negedge iClock);
    iMove = 0; iReset = 0;
    @(negedge iClock);
    iReset = 1;
    chk("mid_busy", int'(busy), 0); chk("mid_size", int'(size), 3);
    chk("mid_hx", int'(px[0]), 80); chk("mid_hy", int'(py[0]), 60);
    chk("mid_p3x", int'(px[3]), 77); chk("mid_go", int'(game_over), 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge iClock);
      iMove = ($urandom % 3 == 0);
      iDir = 2'($urandom);
      iPlay = ($urandom % 10 != 0);
      if ($urandom % 2 == 1) begin
        apple_x = 8'(mx[0] + int'($urandom_range(0, 2)) - 1);
        apple_y = 7'(my[0] + int'($urandom_range(0, 2)) - 1);
      end
      iReset = !((mgo && $urandom % 20 == 0) || $urandom % 700 == 0);
    end
    @(negedge iClock);
    iReset = 1; iMove = 0;
    @(negedge iClock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
